ztimer_readout: RTL and testbench

//   Downstream consumer of the ring-oscillator timers' elapsed_count buses.
//   On host request it selects one timer, captures a stable snapshot despite
//   the count running in the oscillator's asynchronous domain, and streams it
//   out MSB-byte-first over a byte-wide valid/ack port for the top-level pins.

---
 rtl/ztimer_pkg.sv | 14 +
 rtl/ztimer_stable_sampler.sv | 67 ++++++
 rtl/ztimer_readout.sv | 162 ++++++++++++++++
 tb/tb_ztimer_readout.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ztimer_pkg.sv
// Shared types and defaults for the ring-oscillator timer readout.
package ztimer_pkg;

    localparam int unsigned DEFAULT_CNT_W = 32;
    localparam int unsigned BYTES_PER_CNT = DEFAULT_CNT_W / 8;

    typedef enum logic [1:0] {
        StIdle,
        StSample,
        StCompare,
        StShift
    } rd_state_e;

endpackage

// File: rtl/ztimer_stable_sampler.sv
// Captures an asynchronously running count and re-compares it until two
// consecutive samples agree or the retry budget runs out.
module ztimer_stable_sampler
    import ztimer_pkg::*;
#(
    parameter int unsigned CNT_W     = DEFAULT_CNT_W,
    parameter int unsigned MAX_RETRY = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic             done_o,
    output logic [CNT_W-1:0] snap_o,
    output logic             unstable_o
);

    localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);

    logic              active_q, active_d;
    logic [CNT_W-1:0]  snap_q, snap_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [RetryW-1:0] retry_inc;

    always_comb begin
        active_d   = active_q;
        snap_d     = snap_q;
        retry_d    = retry_q;
        done_o     = 1'b0;
        unstable_o = 1'b0;
        retry_inc  = retry_q + 1'b1;
        if (start_i) begin
            active_d = 1'b1;
            snap_d   = cnt_i;
            retry_d  = '0;
        end else if (active_q) begin
            if (cnt_i == snap_q) begin
                done_o   = 1'b1;
                active_d = 1'b0;
            end else begin
                snap_d  = cnt_i;
                retry_d = retry_inc;
                // Give up with the most recent sample once the budget is spent.
                if (retry_inc == RetryW'(MAX_RETRY)) begin
                    done_o     = 1'b1;
                    unstable_o = 1'b1;
                    active_d   = 1'b0;
                end
            end
        end
    end

    assign snap_o = snap_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            snap_q   <= '0;
            retry_q  <= '0;
        end else begin
            active_q <= active_d;
            snap_q   <= snap_d;
            retry_q  <= retry_d;
        end
    end

endmodule

// File: rtl/ztimer_readout.sv
// Selects one timer count, takes a stable snapshot and streams it MSB byte first.
// ZTIMER_READOUT_CHK_EN appends an XOR checksum byte to each frame.
module ztimer_readout
    import ztimer_pkg::*;
#(
    parameter int unsigned N_TIMERS  = 4,
    parameter int unsigned CNT_W     = BYTES_PER_CNT * 8,
    parameter int unsigned MAX_RETRY = 7
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         rd_req_i,
    input  logic [(N_TIMERS > 1 ? $clog2(N_TIMERS) : 1)-1:0] rd_sel_i,
    input  logic [N_TIMERS*CNT_W-1:0]                    cnt_bus_i,
    input  logic                                         byte_ack_i,
    output logic [7:0]                                   dout_o,
    output logic                                         dout_valid_o,
    output logic                                         frame_last_o,
    output logic                                         busy_o,
    output logic                                         unstable_o
);

    localparam int unsigned SelW   = (N_TIMERS > 1) ? $clog2(N_TIMERS) : 1;
    localparam int unsigned NBytes = CNT_W / 8;
`ifdef ZTIMER_READOUT_CHK_EN
    localparam int unsigned FrameBytes = NBytes + 1;
`else
    localparam int unsigned FrameBytes = NBytes;
`endif
    localparam int unsigned IdxW = $clog2(FrameBytes + 1);

    rd_state_e         state_q, state_d;
    logic [SelW-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]  snap_q, snap_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [7:0]        dout_q, dout_d;
    logic              valid_q, valid_d, last_q, last_d;
    logic              busy_q, busy_d, unst_q, unst_d;
    logic [CNT_W-1:0]  cnt_sel;
    logic              samp_start, samp_done, samp_unstable;
    logic [CNT_W-1:0]  samp_snap;

    function automatic logic [7:0] frame_byte(input logic [CNT_W-1:0] snap,
                                              input logic [IdxW-1:0]  idx);
        logic [7:0] b;
        b = '0;
        for (int j = 0; j < NBytes; j++) begin
            if (idx == IdxW'(j)) b = snap[CNT_W-1-8*j -: 8];
        end
`ifdef ZTIMER_READOUT_CHK_EN
        if (idx == IdxW'(NBytes)) begin
            for (int j = 0; j < NBytes; j++) b = b ^ snap[8*j +: 8];
        end
`endif
        return b;
    endfunction

    // Out-of-range selects leave the count at zero, which always reads as stable.
    always_comb begin
        cnt_sel = '0;
        for (int i = 0; i < N_TIMERS; i++) begin
            if (sel_q == SelW'(i)) cnt_sel = cnt_bus_i[i*CNT_W +: CNT_W];
        end
    end

    ztimer_stable_sampler #(
        .CNT_W    (CNT_W),
        .MAX_RETRY(MAX_RETRY)
    ) u_sampler (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (samp_start),
        .cnt_i     (cnt_sel),
        .done_o    (samp_done),
        .snap_o    (samp_snap),
        .unstable_o(samp_unstable)
    );

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        snap_d     = snap_q;
        idx_d      = idx_q;
        dout_d     = dout_q;
        valid_d    = valid_q;
        last_d     = last_q;
        busy_d     = busy_q;
        unst_d     = unst_q;
        samp_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rd_req_i) begin
                    sel_d   = rd_sel_i;
                    unst_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StSample;
                end
            end
            StSample: begin
                samp_start = 1'b1;
                state_d    = StCompare;
            end
            StCompare: begin
                if (samp_done) begin
                    snap_d  = samp_snap;
                    idx_d   = '0;
                    dout_d  = frame_byte(samp_snap, IdxW'(0));
                    valid_d = 1'b1;
                    last_d  = (FrameBytes == 1);
                    unst_d  = samp_unstable;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (byte_ack_i && valid_q) begin
                    if (idx_q == IdxW'(FrameBytes - 1)) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        dout_d = frame_byte(snap_q, idx_q + 1'b1);
                        last_d = ((idx_q + 1'b1) == IdxW'(FrameBytes - 1));
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            sel_q   <= '0;
            snap_q  <= '0;
            idx_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            unst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            unst_q  <= unst_d;
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;
    assign frame_last_o = last_q;
    assign busy_o       = busy_q;
    assign unstable_o   = unst_q;

endmodule

// File: tb/tb_ztimer_readout.sv
// Directed bench for ztimer_readout: table-driven frames plus stall, reset,
// unstable-count and request-on-last-ack sequences.
module tb_ztimer_readout;

`ifdef ZTIMER_READOUT_CHK_EN
    localparam int FB = 5;
`else
    localparam int FB = 4;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_req;
    logic [1:0]   rd_sel;
    logic [127:0] cnt_bus;
    logic         byte_ack;
    logic [7:0]   dout;
    logic         dout_valid, frame_last, busy, unstable;

    logic [31:0]  cnt [4];
    logic         inc_en = 1'b0;
    logic [7:0]   exp_b [5];
    int           checks = 0;
    int           errors = 0;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] val;
        logic [7:0]  eb [5];
    } vec_t;
    vec_t vecs [5];

    assign cnt_bus = {cnt[3], cnt[2], cnt[1], cnt[0]};

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        if (inc_en) cnt[1] = cnt[1] + 32'd1;
    end

    ztimer_readout dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rd_req_i    (rd_req),
        .rd_sel_i    (rd_sel),
        .cnt_bus_i   (cnt_bus),
        .byte_ack_i  (byte_ack),
        .dout_o      (dout),
        .dout_valid_o(dout_valid),
        .frame_last_o(frame_last),
        .busy_o      (busy),
        .unstable_o  (unstable)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a request and drain the frame with ack held high.
    task automatic run_frame(input logic [1:0] sel, input int exp_lat, input bit chk_bytes,
                             input bit exp_unst, input int stall_len, input bit req_on_last);
        int lat;
        rd_sel = sel;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("busy_after_req", {31'd0, busy}, 32'd1);
        check("unstable_cleared_on_req", {31'd0, unstable}, 32'd0);
        lat = 0;
        while (dout_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check("first_byte_latency", lat, exp_lat);
        check("unstable_flag", {31'd0, unstable}, {31'd0, exp_unst});
        byte_ack = 1'b1;
        for (int b = 0; b < FB; b++) begin
            if (chk_bytes) check($sformatf("byte%0d", b), {24'd0, dout}, {24'd0, exp_b[b]});
            check($sformatf("valid%0d", b), {31'd0, dout_valid}, 32'd1);
            check($sformatf("last%0d", b), {31'd0, frame_last}, (b == FB - 1) ? 32'd1 : 32'd0);
            if (b == 1 && stall_len > 0) begin
                byte_ack = 1'b0;
                rd_req   = 1'b1;
                rd_sel   = 2'd0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    check("stall_dout", {24'd0, dout}, {24'd0, exp_b[1]});
                    check("stall_valid", {31'd0, dout_valid}, 32'd1);
                    check("stall_busy", {31'd0, busy}, 32'd1);
                end
                rd_req   = 1'b0;
                byte_ack = 1'b1;
            end
            if (b == FB - 1 && req_on_last) rd_req = 1'b1;
            tick();
            rd_req = 1'b0;
        end
        byte_ack = 1'b0;
        check("end_valid", {31'd0, dout_valid}, 32'd0);
        check("end_last", {31'd0, frame_last}, 32'd0);
        check("end_busy", {31'd0, busy}, 32'd0);
        if (chk_bytes) check("end_dout_hold", {24'd0, dout}, {24'd0, exp_b[FB-1]});
        if (req_on_last) begin
            tick();
            check("no_new_frame_busy", {31'd0, busy}, 32'd0);
            tick();
            check("no_new_frame_valid", {31'd0, dout_valid | busy}, 32'd0);
        end
    endtask

    task automatic load_vec(input int i);
        for (int t = 0; t < 4; t++) cnt[t] = 32'hC0DE_0000 + t;
        cnt[vecs[i].sel] = vecs[i].val;
        for (int b = 0; b < 5; b++) exp_b[b] = vecs[i].eb[b];
    endtask

    initial begin
        vecs[0] = '{sel: 2'd2, val: 32'h1234_5678, eb: '{8'h12, 8'h34, 8'h56, 8'h78, 8'h08}};
        vecs[1] = '{sel: 2'd0, val: 32'hA5A5_0F0F, eb: '{8'hA5, 8'hA5, 8'h0F, 8'h0F, 8'h00}};
        vecs[2] = '{sel: 2'd3, val: 32'h0102_0304, eb: '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04}};
        vecs[3] = '{sel: 2'd1, val: 32'hFFFF_FFFF, eb: '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00}};
        vecs[4] = '{sel: 2'd0, val: 32'hDEAD_BEEF, eb: '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22}};

        rst = 1'b1; rd_req = 1'b0; rd_sel = 2'd0; byte_ack = 1'b0;
        for (int t = 0; t < 4; t++) cnt[t] = '0;
        tick();
        tick();
        check("rst_dout", {24'd0, dout}, 32'd0);
        check("rst_flags", {28'd0, dout_valid, frame_last, busy, unstable}, 32'd0);
        rst = 1'b0;
        tick();

        // Static counts through the selector, ack every cycle.
        for (int i = 0; i < 5; i++) begin
            load_vec(i);
            run_frame(vecs[i].sel, 2, 1'b1, 1'b0, 0, 1'b0);
            tick();
        end

        // Free-running count on timer 1 exhausts the retries.
        cnt[1] = 32'h0000_1000;
        inc_en = 1'b1;
        run_frame(2'd1, 8, 1'b0, 1'b1, 0, 1'b0);
        inc_en = 1'b0;
        tick();
        check("unstable_held_in_idle", {31'd0, unstable}, 32'd1);
        load_vec(0);
        run_frame(vecs[0].sel, 2, 1'b1, 1'b0, 0, 1'b0);
        tick();

        // Five-cycle stall on byte 1 with an ignored request during the stall.
        load_vec(2);
        run_frame(vecs[2].sel, 2, 1'b1, 1'b0, 5, 1'b0);
        tick();
        check("idle_after_stall_req", {31'd0, busy}, 32'd0);

        // Asynchronous reset while byte 1 is presented.
        load_vec(0);
        rd_sel = 2'd2;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        tick();
        byte_ack = 1'b1;
        tick();
        byte_ack = 1'b0;
        check("pre_rst_byte1", {24'd0, dout}, 32'h34);
        rst = 1'b1;
        #1;
        check("async_rst_dout", {24'd0, dout}, 32'd0);
        check("async_rst_flags", {28'd0, dout_valid, frame_last, busy, unstable}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run_frame(vecs[0].sel, 2, 1'b1, 1'b0, 0, 1'b0);
        tick();

        // Request coincident with the final ack.
        load_vec(4);
        run_frame(vecs[4].sel, 2, 1'b1, 1'b0, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
